// File: rtl/ram_delay_ctrl_if.sv
// rtl/ram_delay_ctrl_if.sv - sample stream, delay-line RAM and delayed output bundle
interface ram_delay_ctrl_if #(
    parameter int P_NBITS_DATA = 42,
    parameter int P_NBITS_ADDR = 9
);
    logic                    s_valid;
    logic [P_NBITS_DATA-1:0] s_data;
    logic                    s_ready;
    logic                    ram_wr;
    logic [P_NBITS_DATA-1:0] ram_d;
    logic [P_NBITS_ADDR-1:0] ram_n;
    logic                    ram_valid;
    logic [P_NBITS_DATA-1:0] ram_qn;
    logic                    m_valid;
    logic [P_NBITS_DATA-1:0] m_data;

    modport slave (
        input  s_valid, s_data, ram_valid, ram_qn,
        output s_ready, ram_wr, ram_d, ram_n, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, ram_valid, ram_qn,
        input  s_ready, ram_wr, ram_d, ram_n, m_valid, m_data
    );
endinterface

// File: rtl/ram_delay_ctrl.sv
// rtl/ram_delay_ctrl.sv - delay-line RAM controller; RAM_DELAY_CTRL_STATS_EN enables drop_cnt
module ram_delay_ctrl #(
    parameter int P_NBITS_DATA = 42,
    parameter int P_NBITS_ADDR = 9,
    parameter int P_FLUSH_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    ram_delay_ctrl_if.slave         bus,
    input  logic [P_NBITS_ADDR-1:0] n_cfg,
    input  logic                    n_load,
    output logic                    busy,
    output logic [P_NBITS_ADDR-1:0] fill_cnt,
    output logic [15:0]             drop_cnt
);
    localparam int FW = (P_FLUSH_CYC > 1) ? $clog2(P_FLUSH_CYC) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(P_FLUSH_CYC - 1);
    localparam logic [P_NBITS_ADDR-1:0] N_ONE = P_NBITS_ADDR'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t                  state_q, state_d;
    logic [P_NBITS_ADDR-1:0] ram_n_q, ram_n_d;
    logic [P_NBITS_ADDR-1:0] pend_q, pend_d;
    logic [P_NBITS_ADDR-1:0] fill_q, fill_d;
    logic [FW-1:0]           flush_q, flush_d;
    logic                    m_valid_q;
    logic [P_NBITS_DATA-1:0] m_data_q;

    logic                    accept;
    logic [P_NBITS_ADDR-1:0] n_clamp;
    logic [P_NBITS_ADDR-1:0] fill_inc;

    assign bus.s_ready = !rst && (state_q != ST_FLUSH);
    assign accept      = bus.s_valid && bus.s_ready;
    assign bus.ram_wr  = accept;
    assign bus.ram_d   = bus.s_data;
    assign bus.ram_n   = ram_n_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign busy        = (state_q == ST_FILL) || (state_q == ST_FLUSH);
    assign fill_cnt    = fill_q;

    assign n_clamp  = (n_cfg == '0) ? N_ONE : n_cfg;
    assign fill_inc = fill_q + N_ONE;

    always_comb begin
        state_d = state_q;
        ram_n_d = ram_n_q;
        pend_d  = pend_q;
        fill_d  = fill_q;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    fill_d  = N_ONE;
                    state_d = (ram_n_q == N_ONE) ? ST_RUN : ST_FILL;
                end
                if (n_load) begin
                    ram_n_d = n_clamp;
                    pend_d  = n_clamp;
                end
            end
            ST_FILL, ST_RUN: begin
                // >= keeps FILL from stalling if ram_n ever lands below fill_cnt
                if (accept && (state_q == ST_FILL)) begin
                    fill_d = fill_inc;
                    if (fill_inc >= ram_n_q) begin
                        fill_d  = ram_n_q;
                        state_d = ST_RUN;
                    end
                end
                if (n_load) begin
                    pend_d  = n_clamp;
                    flush_d = '0;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (n_load) begin
                    pend_d  = n_clamp;
                    flush_d = '0;
                end else if (flush_q == FLUSH_LAST) begin
                    ram_n_d = pend_q;
                    fill_d  = '0;
                    state_d = ST_FILL;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ram_n_q   <= N_ONE;
            pend_q    <= N_ONE;
            fill_q    <= '0;
            flush_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            ram_n_q   <= ram_n_d;
            pend_q    <= pend_d;
            fill_q    <= fill_d;
            flush_q   <= flush_d;
            m_valid_q <= bus.ram_valid && (state_q == ST_RUN);
            m_data_q  <= bus.ram_qn;
        end
    end

`ifdef RAM_DELAY_CTRL_STATS_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (bus.s_valid && !bus.s_ready && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_ram_delay_ctrl.sv
// tb/tb_ram_delay_ctrl.sv - bench for ram_delay_ctrl with delay-line RAM stand-in and reference model
module tb_ram_delay_ctrl;
    localparam int D  = 42;
    localparam int A  = 9;
    localparam int FC = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [A-1:0] n_cfg = '0;
    logic         n_load = 1'b0;
    logic         busy;
    logic [A-1:0] fill_cnt;
    logic [15:0]  drop_cnt;

    int n_pass = 0;
    int n_total = 0;

    ram_delay_ctrl_if #(.P_NBITS_DATA(D), .P_NBITS_ADDR(A)) bus ();

    ram_delay_ctrl #(.P_NBITS_DATA(D), .P_NBITS_ADDR(A), .P_FLUSH_CYC(FC)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .n_cfg    (n_cfg),
        .n_load   (n_load),
        .busy     (busy),
        .fill_cnt (fill_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Delay-line RAM: each write returns the sample written ram_n writes earlier
    logic [D-1:0] mem [512];
    logic [8:0]   wptr = '0;
    logic [8:0]   rptr;
    initial for (int i = 0; i < 512; i++) mem[i] = '0;
    assign rptr          = wptr - bus.ram_n;
    assign bus.ram_valid = bus.ram_wr;
    assign bus.ram_qn    = mem[rptr];
    always @(posedge clk) begin
        if (bus.ram_wr) begin
            mem[wptr] <= bus.ram_d;
            wptr      <= wptr + 9'd1;
        end
    end

    // Reference model: epoch write count vs. delay, blocked-window countdown, sample history
    int           n_m = 1, pend_m = 1, cnt = 0, flush_left = 0, drop_m = 0, nc = 1;
    bit           idle = 1'b1, exp_mv = 1'b0, wr_m = 1'b0, was_idle = 1'b1;
    logic [D-1:0] exp_md = '0;
    logic [D-1:0] hist [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n_m = 1; pend_m = 1; cnt = 0; flush_left = 0; drop_m = 0;
            idle = 1'b1; exp_mv = 1'b0; hist.delete();
        end else begin
            wr_m     = bus.s_valid && (flush_left == 0);
            was_idle = idle;
            nc       = (n_cfg == '0) ? 1 : int'(n_cfg);
            exp_mv   = wr_m && (cnt >= n_m);
            if (exp_mv) exp_md = hist[hist.size() - n_m];
`ifdef RAM_DELAY_CTRL_STATS_EN
            if (bus.s_valid && !wr_m && drop_m < 65535) drop_m++;
`endif
            if (wr_m) begin
                hist.push_back(bus.s_data);
                cnt++;
                idle = 1'b0;
            end
            if (flush_left > 0) begin
                if (n_load) begin
                    pend_m = nc;
                    flush_left = FC;
                end else begin
                    flush_left--;
                    if (flush_left == 0) begin
                        n_m = pend_m;
                        cnt = 0;
                    end
                end
            end else if (n_load) begin
                pend_m = nc;
                if (was_idle) n_m = nc;
                else flush_left = FC;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    bit exp_sready, exp_wr, exp_busy;
    int exp_fill;
    always @(negedge clk) begin
        exp_sready = !rst && (flush_left == 0);
        exp_wr     = bus.s_valid && exp_sready;
        exp_fill   = (cnt < n_m) ? cnt : n_m;
        exp_busy   = !idle && ((flush_left > 0) || (cnt < n_m));
        chk("s_ready", 64'(bus.s_ready), 64'(exp_sready));
        chk("ram_wr", 64'(bus.ram_wr), 64'(exp_wr));
        chk("ram_d", 64'(bus.ram_d), 64'(bus.s_data));
        chk("ram_n", 64'(bus.ram_n), 64'(n_m));
        chk("fill_cnt", 64'(fill_cnt), 64'(exp_fill));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("m_valid", 64'(bus.m_valid), 64'(exp_mv));
        if (exp_mv) chk("m_data", 64'(bus.m_data), 64'(exp_md));
        chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
    end

    task automatic drive(input bit v, input logic [D-1:0] d, input bit ld, input logic [A-1:0] cfg);
        bus.s_valid = v;
        bus.s_data  = d;
        n_load      = ld;
        n_cfg       = cfg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        drive(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ram_n", 64'(bus.ram_n), 64'd1);
        chk("rst_fill", 64'(fill_cnt), 64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_data", 64'(bus.m_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // n=4 in IDLE, then samples 1..10
        drive(1'b0, '0, 1'b1, 9'd4);
        chk("idle_load_n", 64'(bus.ram_n), 64'd4);
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, D'(k), 1'b0, '0);
            chk("fill_ramp", 64'(fill_cnt), 64'((k < 4) ? k : 4));
            if (k == 4) begin
                chk("run_busy", 64'(busy), 64'd0);
                chk("no_mv_at_4", 64'(bus.m_valid), 64'd0);
            end
            if (k == 5) chk("first_out", 64'(bus.m_data), 64'd1);
        end
        chk("out_10", 64'(bus.m_data), 64'd6);

        // reconfigure to 8 in RUN with a concurrent sample
        drive(1'b1, D'(11), 1'b1, 9'd8);
        chk("old_n_mv", 64'(bus.m_valid), 64'd1);
        chk("old_n_md", 64'(bus.m_data), 64'd7);
        chk("flush_rdy0", 64'(bus.s_ready), 64'd0);
        idle_cyc();
        chk("flush_rdy1", 64'(bus.s_ready), 64'd0);
        idle_cyc();
        chk("new_n8", 64'(bus.ram_n), 64'd8);
        chk("refill_rdy", 64'(bus.s_ready), 64'd1);
        for (int k = 101; k <= 109; k++) begin
            drive(1'b1, D'(k), 1'b0, '0);
            if (k == 108) chk("n8_no_mv", 64'(bus.m_valid), 64'd0);
        end
        chk("n8_mv", 64'(bus.m_valid), 64'd1);
        chk("n8_md", 64'(bus.m_data), 64'd101);

        // loads stacked inside FLUSH restart it
        drive(1'b0, '0, 1'b1, 9'd5);
        drive(1'b0, '0, 1'b1, 9'd6);
        drive(1'b0, '0, 1'b1, 9'd3);
        chk("restart_rdy0", 64'(bus.s_ready), 64'd0);
        idle_cyc();
        chk("restart_rdy1", 64'(bus.s_ready), 64'd0);
        idle_cyc();
        chk("restart_n3", 64'(bus.ram_n), 64'd3);
        chk("restart_busy", 64'(busy), 64'd1);

        // n_cfg=0 clamps to 1
        drive(1'b0, '0, 1'b1, 9'd0);
        idle_cyc();
        idle_cyc();
        chk("clamp_n1", 64'(bus.ram_n), 64'd1);
        drive(1'b1, D'(200), 1'b0, '0);
        chk("n1_run", 64'(busy), 64'd0);
        chk("n1_fill", 64'(fill_cnt), 64'd1);
        drive(1'b1, D'(201), 1'b0, '0);
        chk("n1_mv", 64'(bus.m_valid), 64'd1);
        chk("n1_md", 64'(bus.m_data), 64'd200);
        idle_cyc();

        // reset mid-FILL
        drive(1'b0, '0, 1'b1, 9'd4);
        idle_cyc();
        idle_cyc();
        drive(1'b1, D'(300), 1'b0, '0);
        drive(1'b1, D'(301), 1'b0, '0);
        chk("pre_rst_fill", 64'(fill_cnt), 64'd2);
        bus.s_data = D'(302);
        rst = 1'b1;
        #1;
        chk("rst_wr", 64'(bus.ram_wr), 64'd0);
        chk("rst_rdy", 64'(bus.s_ready), 64'd0);
        chk("rst_fill0", 64'(fill_cnt), 64'd0);
        chk("rst_n1", 64'(bus.ram_n), 64'd1);
        chk("rst_mv0", 64'(bus.m_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_wr_hold", 64'(bus.ram_wr), 64'd0);
        rst = 1'b0;
        idle_cyc();

        // drops while s_valid is held through FLUSH
        drive(1'b0, '0, 1'b1, 9'd2);
        drive(1'b1, D'(1), 1'b0, '0);
        drive(1'b1, D'(2), 1'b0, '0);
        drive(1'b1, D'(3), 1'b0, '0);
        chk("n2_md", 64'(bus.m_data), 64'd1);
        drive(1'b1, D'(4), 1'b1, 9'd3);
        drive(1'b1, D'(5), 1'b0, '0);
        drive(1'b1, D'(5), 1'b0, '0);
        idle_cyc();
`ifdef RAM_DELAY_CTRL_STATS_EN
        chk("drop_cnt2", 64'(drop_cnt), 64'd2);
`else
        chk("drop_cnt0", 64'(drop_cnt), 64'd0);
`endif
        idle_cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ram_delay_ctrl.md
RAM_DELAY_CTRL -- requirements
Module: ram_delay_ctrl

Interface
REQ-001 SHALL have parameter P_NBITS_DATA, default 42, sample width.
REQ-002 SHALL have parameter P_NBITS_ADDR, default 9, delay/address width.
REQ-003 SHALL have parameter P_FLUSH_CYC, default 2, settle cycles spent in FLUSH.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports s_valid in 1, s_data in P_NBITS_DATA, s_ready out 1: upstream sample handshake.
REQ-007 SHALL have ports n_cfg in P_NBITS_ADDR, n_load in 1: requested delay and one-cycle load strobe.
REQ-008 SHALL have ports ram_wr out 1, ram_d out P_NBITS_DATA, ram_n out P_NBITS_ADDR: drive delay-line RAM write, data and delay.
REQ-009 SHALL have ports ram_valid in 1, ram_qn in P_NBITS_DATA: delay-line output strobe and delayed sample.
REQ-010 SHALL have ports m_valid out 1, m_data out P_NBITS_DATA: qualified delayed output.
REQ-011 SHALL have ports busy out 1, fill_cnt out P_NBITS_ADDR, drop_cnt out 16: status.

Function
REQ-012 SHALL implement FSM states IDLE, FILL, RUN, FLUSH.
REQ-013 SHALL hold s_ready=1 in IDLE, FILL, RUN and s_ready=0 in FLUSH.
REQ-014 SHALL drive ram_wr = s_valid & s_ready and ram_d = s_data combinationally, so each accepted sample is written to the RAM in its handshake cycle.
REQ-015 SHALL transition IDLE->FILL on first accepted sample, counting that sample in fill_cnt.
REQ-016 SHALL increment fill_cnt by 1 per accepted sample in FILL and transition FILL->RUN on the write that makes fill_cnt equal ram_n.
REQ-017 SHALL hold fill_cnt at ram_n in RUN (no wrap).
REQ-018 SHALL register m_valid <= ram_valid & (state==RUN) and m_data <= ram_qn, giving exactly 1 cycle latency from ram_valid.
REQ-019 SHALL keep m_valid=0 in IDLE, FILL and FLUSH so stale RAM contents never reach the output.
REQ-020 SHALL on n_load latch n_cfg into a pending register, clamping 0 to 1.
REQ-021 SHALL on n_load in FILL or RUN transition to FLUSH next cycle; a sample accepted in the same cycle as n_load is written under the old ram_n.
REQ-022 SHALL in FLUSH hold ram_wr=0 for P_FLUSH_CYC cycles, then update ram_n from pending, clear fill_cnt, and transition to FILL.
REQ-023 SHALL on n_load during FLUSH overwrite the pending value and restart the FLUSH cycle count.
REQ-024 SHALL on n_load in IDLE update ram_n directly (clamped) and stay in IDLE.
REQ-025 SHALL assert busy when state is FILL or FLUSH.

Reset
REQ-026 SHALL on rst force, asynchronously: state=IDLE, ram_n=1, pending=1, fill_cnt=0, m_valid=0, m_data=0, drop_cnt=0, flush count=0.
REQ-027 SHALL on reset assertion mid-FILL, RUN or FLUSH abandon the operation with no further RAM writes; ram_wr=0 while rst=1.
REQ-028 SHALL hold s_ready=0 while rst=1.

Configuration
REQ-029 SHALL, with RAM_DELAY_CTRL_STATS_EN defined, increment drop_cnt once per cycle with s_valid=1 & s_ready=0 (excluding rst), saturating at 16'hFFFF.
REQ-030 SHALL, without RAM_DELAY_CTRL_STATS_EN, tie drop_cnt to 0 with no counter logic.

Verification
REQ-031 SHALL cover: reset, n_cfg=4 + n_load, 10 consecutive samples 1..10 -> fill_cnt 1..4, RUN after 4th write, m_valid only in RUN, m_data = sample k-4 one cycle after ram_valid.
REQ-032 SHALL cover: in RUN, n_cfg=8 + n_load with s_valid=1 -> that sample written under n=4, s_ready=0 for 2 cycles, ram_n=8, 8 further writes before m_valid.
REQ-033 SHALL cover: n_load (n_cfg=6) on 1st FLUSH cycle, then n_cfg=3 on 2nd -> FLUSH restarts, lasts 2 cycles after last load, ram_n=3.
REQ-034 SHALL cover: n_cfg=0 + n_load -> ram_n=1, RUN after first write.
REQ-035 SHALL cover: rst pulse after 2 of 4 fill writes -> IDLE, fill_cnt=0, ram_n=1, m_valid=0, no ram_wr while rst high.
REQ-036 SHALL cover: STATS_EN defined, s_valid held through 2-cycle FLUSH -> drop_cnt=2; undefined -> drop_cnt=0.
